// File: rtl/serial_branch_comp_pkg.sv
// Shared definitions for the serial branch-condition evaluator.
//   XLEN     : default operand width
//   state_t  : control FSM encoding
//   F3_*     : RV32I branch funct3 codes
package serial_branch_comp_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/serial_branch_comp_fourbits.sv
// 4-bit cascadable magnitude comparator.
//   a, b                   : nibbles compared at this significance
//   eq_in, lt_in, gt_in    : result of the lower-significance nibbles
//   eq_out, lt_out, gt_out : combined result
// A difference at this nibble overrides the cascade. Equal nibbles pass
// the cascade through unchanged.
module fourbits_comp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       eq_in,
  input  logic       lt_in,
  input  logic       gt_in,
  output logic       eq_out,
  output logic       lt_out,
  output logic       gt_out
);

  always_comb begin
    eq_out = eq_in;
    lt_out = lt_in;
    gt_out = gt_in;
    if (a < b) begin
      eq_out = 1'b0;
      lt_out = 1'b1;
      gt_out = 1'b0;
    end else if (a > b) begin
      eq_out = 1'b0;
      lt_out = 1'b0;
      gt_out = 1'b1;
    end
  end

endmodule

// File: rtl/serial_branch_comp.sv
// Multi-cycle RV32I branch-condition evaluator. Operands are compared one
// nibble per cycle, LSB nibble first, through a single 4-bit comparator
// cell whose outputs are registered and fed back as the cascade.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : request handshake (rs1, rs2, funct3)
//   flush                : aborts the in-flight request
//   out_valid / out_ready: result handshake (taken, eq, lt, illegal)
module serial_branch_comp #(
  parameter int unsigned XLEN = serial_branch_comp_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            eq,
  output logic            lt,
  output logic            illegal
);

  import serial_branch_comp_pkg::*;

  localparam int unsigned NSTEP = XLEN / 4;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  state_t state, state_nxt;

  logic [XLEN-1:0] a_reg, b_reg;
  logic [2:0]      f3_reg;
  logic [CW-1:0]   cnt;
  logic            c_eq, c_lt, c_gt;

  logic [3:0] a_nib, b_nib;
  logic       n_eq, n_lt, n_gt;
  logic       is_signed, is_illegal, last_step, done;

  assign is_signed  = (f3_reg[2:1] == 2'b10);
  assign is_illegal = (f3_reg[2:1] == 2'b01);
  assign last_step  = (cnt == LAST);
  assign done       = (state == DONE);

  // Inverting both sign bits on the MSB step maps signed order onto
  // unsigned order, so the same magnitude cell serves BLT/BGE.
  always_comb begin
    a_nib = a_reg[{cnt, 2'b00} +: 4];
    b_nib = b_reg[{cnt, 2'b00} +: 4];
    if (is_signed && last_step) begin
      a_nib[3] = ~a_nib[3];
      b_nib[3] = ~b_nib[3];
    end
  end

  fourbits_comp u_cell (
    .a      (a_nib),
    .b      (b_nib),
    .eq_in  (c_eq),
    .lt_in  (c_lt),
    .gt_in  (c_gt),
    .eq_out (n_eq),
    .lt_out (n_lt),
    .gt_out (n_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)                state_nxt = RUN;
      RUN:  if (flush)                   state_nxt = IDLE;
            else if (last_step)          state_nxt = DONE;
      DONE: if (flush || out_ready)      state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      f3_reg <= '0;
      cnt    <= '0;
      c_eq   <= 1'b1;
      c_lt   <= 1'b0;
      c_gt   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_reg  <= rs1;
      b_reg  <= rs2;
      f3_reg <= funct3;
      cnt    <= '0;
      c_eq   <= 1'b1;
      c_lt   <= 1'b0;
      c_gt   <= 1'b0;
    end else if (state == RUN && !flush) begin
      c_eq <= n_eq;
      c_lt <= n_lt;
      c_gt <= n_gt;
      cnt  <= last_step ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = done;
    eq        = done && c_eq;
    lt        = done && c_lt;
    illegal   = done && is_illegal;
    taken     = 1'b0;
    if (done) begin
      case (f3_reg)
        F3_BEQ:  taken = c_eq;
        F3_BNE:  taken = !c_eq;
        F3_BLT:  taken = c_lt;
        F3_BGE:  taken = !c_lt;
        F3_BLTU: taken = c_lt;
        F3_BGEU: taken = !c_lt;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_branch_comp.sv
module tb_serial_branch_comp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        taken, eq, lt, illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;

  serial_branch_comp #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .eq        (eq),
    .lt        (lt),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {eq, lt, taken, illegal} straight from the branch rules.
  function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f3);
    logic m_eq, m_lt, m_tk, m_il;
    m_eq = (a == b);
    m_il = (f3 == 3'd2) || (f3 == 3'd3);
    if (f3 == 3'd4 || f3 == 3'd5) m_lt = ($signed(a) < $signed(b));
    else                          m_lt = (a < b);
    case (f3)
      3'd0: m_tk = m_eq;
      3'd1: m_tk = !m_eq;
      3'd4, 3'd6: m_tk = m_lt;
      3'd5, 3'd7: m_tk = !m_lt;
      default: m_tk = 1'b0;
    endcase
    return {m_eq, m_lt, m_tk, m_il};
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input int unsigned hold);
    logic [3:0]  exp;
    int unsigned lat;
    exp = model(a, b, f3);
    check("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    rs1 = a; rs2 = b; funct3 = f3; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      end
    end while (!out_valid && lat < 30);
    check("latency", lat, 9);
    check("eq", eq, exp[3]);
    check("lt", lt, exp[2]);
    check("taken", taken, exp[1]);
    check("illegal", illegal, exp[0]);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", {eq, lt, taken, illegal}, exp);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consumed_valid", out_valid, 0);
    check("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {out_valid, taken, eq, lt, illegal}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    do_req(32'h12345678, 32'h12345678, 3'b000, 0);
    do_req(32'hFFFFFFFF, 32'h00000001, 3'b100, 0);
    do_req(32'hFFFFFFFF, 32'h00000001, 3'b110, 0);
    do_req(32'hFFFFFFFF, 32'h00000001, 3'b111, 0);
    do_req(32'h80000000, 32'h7FFFFFFF, 3'b101, 0);
    do_req(32'h80000000, 32'h7FFFFFFF, 3'b001, 0);
    do_req(32'h00000010, 32'h00000011, 3'b110, 0);
    do_req(32'h0000000A, 32'h0000000B, 3'b001, 5);
    do_req(32'h00000007, 32'h00000003, 3'b010, 1);
    do_req(32'hFFFFFFF0, 32'h00000003, 3'b011, 0);

    // Flush on the third RUN cycle.
    rs1 = 32'h1; rs2 = 32'h1; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("flush_no_result", out_valid, 0);
    end
    do_req(32'h5, 32'h5, 3'b000, 0);

    // Async reset pulse mid-RUN, between clock edges.
    rs1 = 32'h9; rs2 = 32'h9; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_outputs", {out_valid, taken, eq, lt, illegal}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_in_ready", in_ready, 1);
    check("rst_release_valid", out_valid, 0);
    do_req(32'h00000009, 32'h00000009, 3'b000, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h0;
        1: a = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: a = 32'h7FFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      do_req(a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
